merge_fifo_n: RTL and testbench
===============================

# merge_fifo_n

Parametrised N-channel merging FIFO: up to N_CH upstream valid/ready channels may each push one word in the same cycle. Accepted words are written in ascending channel index order into one shared show-ahead FIFO. The FIFO drains through a single valid/ready downstream port. It generalises the two-input merge stage with a runtime-independent channel count, a selectable admission mode and a fill-level output.

## Interface
- D_WIDTH, 6, data word width.
- A_WIDTH, 2, address width; DEPTH = 2**A_WIDTH; DEPTH >= N_CH is required.
- N_CH, 2, number of upstream channels, >= 1.
- MODE, 1, admission mode: 0 = all-or-none, 1 = priority partial.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- up_valid  in  N_CH  per-channel valid; bit i belongs to channel i.
- up_ready  out  N_CH  per-channel ready.
- up_data  in  N_CH*D_WIDTH  channel i occupies bits [i*D_WIDTH +: D_WIDTH].
- down_valid  out  1  FIFO not empty.
- down_ready  in  1  consumer accepts the head word.
- down_data  out  D_WIDTH  head word; show-ahead.
- level  out  A_WIDTH+1  number of stored words, 0..DEPTH.

## Operation
- push_i = up_valid[i] & up_ready[i]; pop = down_valid & down_ready.
- The free-space count is free = DEPTH - level, computed from registered level only. Same-cycle pop does not add space.
- up_ready never depends combinationally on up_valid or down_ready.
- MODE 0: every up_ready bit is high iff free >= N_CH; otherwise all bits are low.
- MODE 1: up_ready[i] = (free > i). Lower indices keep priority when space is short.
- Write compaction: the accepted words are written to consecutive slots starting at wr_ptr, lowest channel index first. Channels not pushing leave no gap. wr_ptr advances by the number of pushes k (0..N_CH), modulo DEPTH.
- Read: down_data = mem[rd_ptr] whenever level > 0. A pop advances rd_ptr by 1, modulo DEPTH.
- level_next = level + k - pop. The FIFO can never overflow because admission is bounded by free. It can never underflow because pop requires down_valid.
- Pointers wrap naturally at DEPTH. Wrap-around in the middle of a multi-word write is legal: slots (wr_ptr+j) mod DEPTH.
- Reset (rst=1 at a clock edge): wr_ptr=0, rd_ptr=0, level=0. Storage contents are don't-care.
- While rst is high, up_ready is forced to all zeros and no pushes or pops take effect.
- Reset asserted mid-operation discards all stored words on that edge.

## Timing
- Reset values: down_valid=0, level=0, down_data don't-care. up_ready=0 while rst=1, then all ones in the first cycle after release, since free = DEPTH >= N_CH.
- Push-to-output latency is 1 cycle: a word pushed into an empty FIFO at edge t drives down_valid=1 and down_data in the cycle after t.
- Simultaneous push and pop on a full FIFO is impossible, because up_ready is low when free = 0.
- On a FIFO holding 1 word, push and pop in the same cycle are legal. level is unchanged when k=1.
- up_ready, down_valid, down_data and level are all functions of registered state (plus rst for up_ready). There are no combinational paths from inputs to outputs.
- Throughput: up to N_CH words in per cycle and 1 word out per cycle.

## Test plan
- Reset and idle (N_CH=2, MODE=1): hold rst for 3 cycles, then release.
  - During reset: up_ready=00.
  - After release: up_ready=11, down_valid=0, level=0.
- Dual push ordering:
  - Drive ch0=0x05 and ch1=0x2A, both valid, for one cycle.
  - Required: level=2 next cycle.
  - Then pop twice and read 0x05, then 0x2A.
- Compaction with a gap (N_CH=3, A_WIDTH=2):
  - Push only ch0=0x01 and ch2=0x03 in one cycle.
  - Required: level=2, and the pop order is 0x01, 0x03.
- Partial admission, MODE 1 (DEPTH=4, N_CH=2):
  - Fill to level=3 with down_ready=0; required: up_ready=01.
  - Push ch0=0x11 and ch1=0x22; required: only 0x11 accepted, level=4, up_ready=00.
- All-or-none admission, MODE 0:
  - At level=3; required: up_ready=00.
  - One pop; required: level=2 and up_ready=11 on the next cycle.
- Wrap-around and mid-run reset:
  - Stream random traffic with random down_ready for 200 cycles. The model (a reference queue pushing ch0..chN-1 in order) must match down_data on every pop.
  - Then assert rst with level=3; required: level=0 and down_valid=0 on the following cycle.

Source files
------------

// File: rtl/merge_fifo_n.sv
// merge_fifo_n: N-channel merging FIFO. Words accepted in the same cycle are
// packed into consecutive slots in ascending channel order, then drained one
// per cycle through a show-ahead output port.

// Per-channel admission: a channel is ready once free space reaches its
// threshold. The threshold is N_CH for all-or-none and IDX+1 for priority.
module merge_fifo_n_lane #(
    parameter int A_WIDTH = 2,
    parameter int N_CH    = 2,
    parameter int MODE    = 1,
    parameter int IDX     = 0
) (
    input  logic             rst,
    input  logic [A_WIDTH:0] free,
    output logic             ready
);
    localparam logic [A_WIDTH:0] NEED = (A_WIDTH+1)'((MODE == 0) ? N_CH : IDX + 1);

    assign ready = !rst && (free >= NEED);
endmodule

module merge_fifo_n #(
    parameter int D_WIDTH = 6,
    parameter int A_WIDTH = 2,
    parameter int N_CH    = 2,
    parameter int MODE    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         up_valid,
    output logic [N_CH-1:0]         up_ready,
    input  logic [N_CH*D_WIDTH-1:0] up_data,
    output logic                    down_valid,
    input  logic                    down_ready,
    output logic [D_WIDTH-1:0]      down_data,
    output logic [A_WIDTH:0]        level
);
    localparam int DEPTH = 1 << A_WIDTH;

    logic [D_WIDTH-1:0]         mem [DEPTH];
    logic [A_WIDTH-1:0]         wr_ptr, rd_ptr;
    logic [A_WIDTH:0]           level_q;
    logic [A_WIDTH:0]           free;
    logic [N_CH-1:0]            push;
    logic [N_CH-1:0][A_WIDTH:0] off;
    logic [A_WIDTH:0]           k;
    logic                       pop;

    // Free space comes from registered level only, so ready never sees a
    // same-cycle pop and has no path from any input other than rst.
    assign free = (A_WIDTH+1)'(DEPTH) - level_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        merge_fifo_n_lane #(
            .A_WIDTH(A_WIDTH),
            .N_CH   (N_CH),
            .MODE   (MODE),
            .IDX    (i)
        ) u_lane (
            .rst  (rst),
            .free (free),
            .ready(up_ready[i])
        );
    end

    assign push       = up_valid & up_ready;
    assign down_valid = (level_q != '0);
    assign pop        = down_valid && down_ready && !rst;
    assign down_data  = mem[rd_ptr];
    assign level      = level_q;

    // Slot offset of each channel = number of lower channels pushing; this
    // closes gaps left by idle channels. k ends as the total push count.
    always_comb begin
        k = '0;
        for (int i = 0; i < N_CH; i++) begin
            off[i] = k;
            k      = k + {{A_WIDTH{1'b0}}, push[i]};
        end
    end

    // Storage write: each pushing channel lands at wr_ptr+offset, wrapping
    // naturally through the pointer width.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (push[i])
                mem[wr_ptr + off[i][A_WIDTH-1:0]] <= up_data[i*D_WIDTH +: D_WIDTH];
        end
    end

    // Pointer and fill-level bookkeeping; reset drops all stored words.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            wr_ptr  <= wr_ptr + k[A_WIDTH-1:0];
            rd_ptr  <= rd_ptr + A_WIDTH'(pop);
            level_q <= level_q + k - (A_WIDTH+1)'(pop);
        end
    end
endmodule

// File: tb/tb_merge_fifo_n.sv
// Bench for merge_fifo_n: three instances (2ch priority, 2ch all-or-none,
// 3ch priority), a vector table, corner-case sequences, and a random run
// against a queue model.
module tb_merge_fifo_n;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // instance a: N_CH=2 MODE=1
    logic [1:0]  a_valid, a_ready;
    logic [11:0] a_data;
    logic        a_dv, a_dr;
    logic [5:0]  a_dd;
    logic [2:0]  a_lvl;
    // instance b: N_CH=2 MODE=0
    logic [1:0]  b_valid, b_ready;
    logic [11:0] b_data;
    logic        b_dv, b_dr;
    logic [5:0]  b_dd;
    logic [2:0]  b_lvl;
    // instance c: N_CH=3 MODE=1
    logic [2:0]  c_valid, c_ready;
    logic [17:0] c_data;
    logic        c_dv, c_dr;
    logic [5:0]  c_dd;
    logic [2:0]  c_lvl;

    merge_fifo_n #(.D_WIDTH(6), .A_WIDTH(2), .N_CH(2), .MODE(1)) u_a (
        .clk(clk), .rst(rst), .up_valid(a_valid), .up_ready(a_ready), .up_data(a_data),
        .down_valid(a_dv), .down_ready(a_dr), .down_data(a_dd), .level(a_lvl));
    merge_fifo_n #(.D_WIDTH(6), .A_WIDTH(2), .N_CH(2), .MODE(0)) u_b (
        .clk(clk), .rst(rst), .up_valid(b_valid), .up_ready(b_ready), .up_data(b_data),
        .down_valid(b_dv), .down_ready(b_dr), .down_data(b_dd), .level(b_lvl));
    merge_fifo_n #(.D_WIDTH(6), .A_WIDTH(2), .N_CH(3), .MODE(1)) u_c (
        .clk(clk), .rst(rst), .up_valid(c_valid), .up_ready(c_ready), .up_data(c_data),
        .down_valid(c_dv), .down_ready(c_dr), .down_data(c_dd), .level(c_lvl));

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic chk(input string name, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] v;
        logic [5:0] d0;
        logic [5:0] d1;
        logic       dr;
        logic [2:0] lvl;
        logic [1:0] rdy;
        logic       dv;
        logic [5:0] dd;
    } vec_t;

    vec_t    tbl [14];
    logic [5:0] q[$];

    initial begin
        // expected state after the edge on which each vector is applied
        tbl[0]  = '{2'b11, 6'h05, 6'h2A, 1'b0, 3'd2, 2'b11, 1'b1, 6'h05};
        tbl[1]  = '{2'b00, 6'h00, 6'h00, 1'b1, 3'd1, 2'b11, 1'b1, 6'h2A};
        tbl[2]  = '{2'b00, 6'h00, 6'h00, 1'b1, 3'd0, 2'b11, 1'b0, 6'h00};
        tbl[3]  = '{2'b11, 6'h0A, 6'h12, 1'b0, 3'd2, 2'b11, 1'b1, 6'h0A};
        tbl[4]  = '{2'b01, 6'h13, 6'h00, 1'b0, 3'd3, 2'b01, 1'b1, 6'h0A};
        tbl[5]  = '{2'b11, 6'h11, 6'h22, 1'b0, 3'd4, 2'b00, 1'b1, 6'h0A};
        tbl[6]  = '{2'b11, 6'h30, 6'h31, 1'b1, 3'd3, 2'b01, 1'b1, 6'h12};
        tbl[7]  = '{2'b00, 6'h00, 6'h00, 1'b1, 3'd2, 2'b11, 1'b1, 6'h13};
        tbl[8]  = '{2'b11, 6'h15, 6'h16, 1'b1, 3'd3, 2'b01, 1'b1, 6'h11};
        tbl[9]  = '{2'b00, 6'h00, 6'h00, 1'b1, 3'd2, 2'b11, 1'b1, 6'h15};
        tbl[10] = '{2'b01, 6'h17, 6'h00, 1'b1, 3'd2, 2'b11, 1'b1, 6'h16};
        tbl[11] = '{2'b00, 6'h00, 6'h00, 1'b1, 3'd1, 2'b11, 1'b1, 6'h17};
        tbl[12] = '{2'b10, 6'h00, 6'h18, 1'b1, 3'd1, 2'b11, 1'b1, 6'h18};
        tbl[13] = '{2'b00, 6'h00, 6'h00, 1'b1, 3'd0, 2'b11, 1'b0, 6'h00};

        rst = 1'b1;
        a_valid = '0; a_data = '0; a_dr = 1'b0;
        b_valid = '0; b_data = '0; b_dr = 1'b0;
        c_valid = '0; c_data = '0; c_dr = 1'b0;

        // reset and idle
        repeat (3) tick();
        chk("rst a_ready", int'(a_ready), 0);
        chk("rst b_ready", int'(b_ready), 0);
        chk("rst c_ready", int'(c_ready), 0);
        rst = 1'b0;
        tick();
        chk("idle a_ready", int'(a_ready), 3);
        chk("idle a_dv", int'(a_dv), 0);
        chk("idle a_lvl", int'(a_lvl), 0);
        chk("idle c_ready", int'(c_ready), 7);

        // compaction with a gap on the 3-channel instance
        c_valid = 3'b101; c_data = {6'h03, 6'h3F, 6'h01};
        tick();
        c_valid = '0;
        chk("gap lvl", int'(c_lvl), 2);
        chk("gap ready", int'(c_ready), 3);
        chk("gap head0", int'(c_dd), 'h01);
        c_dr = 1'b1;
        tick();
        chk("gap head1", int'(c_dd), 'h03);
        chk("gap lvl1", int'(c_lvl), 1);
        tick();
        c_dr = 1'b0;
        chk("gap empty", int'(c_dv), 0);

        // all-or-none admission
        b_valid = 2'b11; b_data = {6'h02, 6'h01};
        tick();
        chk("aon lvl2", int'(b_lvl), 2);
        chk("aon rdy2", int'(b_ready), 3);
        b_valid = 2'b01; b_data = {6'h00, 6'h03};
        tick();
        chk("aon lvl3", int'(b_lvl), 3);
        chk("aon rdy3", int'(b_ready), 0);
        b_valid = 2'b11; b_data = {6'h3E, 6'h3D}; b_dr = 1'b1;
        tick();
        b_valid = '0; b_dr = 1'b0;
        chk("aon pop lvl", int'(b_lvl), 2);
        chk("aon pop rdy", int'(b_ready), 3);
        chk("aon pop head", int'(b_dd), 'h02);

        // vector table on the priority instance
        for (int i = 0; i < 14; i++) begin
            a_valid = tbl[i].v;
            a_data  = {tbl[i].d1, tbl[i].d0};
            a_dr    = tbl[i].dr;
            tick();
            chk($sformatf("vec%0d lvl", i), int'(a_lvl), int'(tbl[i].lvl));
            chk($sformatf("vec%0d rdy", i), int'(a_ready), int'(tbl[i].rdy));
            chk($sformatf("vec%0d dv", i), int'(a_dv), int'(tbl[i].dv));
            if (tbl[i].dv)
                chk($sformatf("vec%0d dd", i), int'(a_dd), int'(tbl[i].dd));
        end

        // random traffic against a queue model
        q.delete();
        for (int cyc = 0; cyc < 200; cyc++) begin
            int free_m;
            logic [1:0] rdy_m;
            a_valid = 2'($urandom);
            a_data  = 12'($urandom);
            a_dr    = 1'($urandom);
            free_m  = 4 - q.size();
            rdy_m   = {free_m > 1, free_m > 0};
            chk("rnd lvl", int'(a_lvl), q.size());
            chk("rnd rdy", int'(a_ready), int'(rdy_m));
            chk("rnd dv", int'(a_dv), int'(q.size() != 0));
            if (q.size() != 0 && a_dr) begin
                chk("rnd pop data", int'(a_dd), int'(q[0]));
                void'(q.pop_front());
            end
            for (int ch = 0; ch < 2; ch++)
                if (a_valid[ch] && rdy_m[ch]) q.push_back(a_data[ch*6 +: 6]);
            tick();
        end

        // drain, refill to 3, then reset mid-run
        a_valid = '0; a_dr = 1'b1;
        for (int n = 0; n < 8 && a_lvl != 0; n++) tick();
        chk("drain lvl", int'(a_lvl), 0);
        a_dr = 1'b0; a_valid = 2'b11; a_data = {6'h22, 6'h21};
        tick();
        a_valid = 2'b01; a_data = {6'h00, 6'h23};
        tick();
        a_valid = '0;
        chk("pre-rst lvl", int'(a_lvl), 3);
        rst = 1'b1;
        tick();
        chk("mid-rst lvl", int'(a_lvl), 0);
        chk("mid-rst dv", int'(a_dv), 0);
        chk("mid-rst rdy", int'(a_ready), 0);
        rst = 1'b0;
        tick();
        chk("post-rst rdy", int'(a_ready), 3);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
